// File: rtl/mem_arb_pkg.sv
// Shared types, funct3 encodings and the data-request legality check used by
// the instruction-fetch / load-store memory arbiter.
package mem_arb_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned F3_W      = 3;
    localparam int unsigned STARVE_CW = 4;

    typedef enum logic [2:0] {
        NONE,
        FETCH,
        DRD,
        DWR,
        DERR
    } owner_t;

    localparam logic [F3_W-1:0] LB           = 3'b000;
    localparam logic [F3_W-1:0] LH           = 3'b001;
    localparam logic [F3_W-1:0] LW           = 3'b010;
    localparam logic [F3_W-1:0] LBU          = 3'b100;
    localparam logic [F3_W-1:0] LHU          = 3'b101;
    localparam logic [F3_W-1:0] SB           = 3'b000;
    localparam logic [F3_W-1:0] SH           = 3'b001;
    localparam logic [F3_W-1:0] SW           = 3'b010;
    localparam logic [F3_W-1:0] FETCH_FUNCT3 = 3'b010;

    // Reserved encodings, misaligned halves/words and unsigned stores are illegal.
    function automatic logic data_req_illegal(
        input logic            write,
        input logic [F3_W-1:0] funct3,
        input logic [1:0]      addr_lo
    );
        logic bad;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        if (funct3[1] && (addr_lo != 2'b00)) begin
            bad = 1'b1;
        end
        if ((funct3[1:0] == 2'b01) && addr_lo[0]) begin
            bad = 1'b1;
        end
        if (write && funct3[2]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Data-first fixed-priority grant with a saturating fetch-starvation counter
// that forces a fetch grant after STARVE_LIMIT consecutive data wins.
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_valid,
    input  logic d_valid,
    output logic grant_fetch,
    output logic grant_data
);

    logic [STARVE_CW-1:0] starve_cnt;
    logic                 force_fetch;

    always_comb begin
        force_fetch = if_valid && (starve_cnt == STARVE_CW'(STARVE_LIMIT));
        grant_data  = !reset && d_valid && !force_fetch;
        grant_fetch = !reset && if_valid && !grant_data;
    end

    // Counts data wins over a waiting fetch; any cycle without that clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_data && if_valid) begin
            if (starve_cnt != STARVE_CW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + STARVE_CW'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store
// unit; the registered read data is steered back to the owner one cycle later.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_req_addr,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rsp_data,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic            d_req_write,
    input  logic [F3_W-1:0] d_req_funct3,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic [XLEN-1:0] d_req_wdata,
    output logic            d_rsp_valid,
    output logic [XLEN-1:0] d_rsp_data,
    output logic            d_rsp_err,
    output logic            mem_write_mem,
    output logic [F3_W-1:0] mem_funct3,
    output logic [XLEN-1:0] mem_write_address,
    output logic [XLEN-1:0] mem_write_data,
    output logic [XLEN-1:0] mem_read_address,
    input  logic [XLEN-1:0] mem_read_data
);

    logic   grant_fetch;
    logic   grant_data;
    logic   d_illegal;
    owner_t owner_d;
    owner_t owner_q;

    mem_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_priority (
        .clk        (clk),
        .reset      (reset),
        .if_valid   (if_req_valid),
        .d_valid    (d_req_valid),
        .grant_fetch(grant_fetch),
        .grant_data (grant_data)
    );

    // Memory drive for the winner of this cycle; errors and idle leave memory quiet.
    always_comb begin
        d_illegal         = data_req_illegal(d_req_write, d_req_funct3, d_req_addr[1:0]);
        if_req_ready      = grant_fetch;
        d_req_ready       = grant_data;
        mem_write_mem     = 1'b0;
        mem_funct3        = FETCH_FUNCT3;
        mem_write_address = '0;
        mem_write_data    = '0;
        mem_read_address  = '0;
        owner_d           = NONE;
        if (grant_fetch) begin
            mem_read_address = if_req_addr;
            owner_d          = FETCH;
        end else if (grant_data) begin
            if (d_illegal) begin
                owner_d = DERR;
            end else if (d_req_write) begin
                mem_write_mem     = 1'b1;
                mem_funct3        = d_req_funct3;
                mem_write_address = d_req_addr;
                mem_write_data    = d_req_wdata;
                owner_d           = DWR;
            end else begin
                mem_funct3       = d_req_funct3;
                mem_read_address = d_req_addr;
                owner_d          = DRD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Reset in the response cycle swallows the pending pulse.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = '0;
        d_rsp_err    = 1'b0;
        if (!reset) begin
            case (owner_q)
                FETCH: begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = mem_read_data;
                end
                DRD: begin
                    d_rsp_valid = 1'b1;
                    d_rsp_data  = mem_read_data;
                end
                DWR: begin
                    d_rsp_valid = 1'b1;
                end
                DERR: begin
                    d_rsp_valid = 1'b1;
                    d_rsp_err   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory, a rule-level reference
// model checked every cycle, and literal expectations for each scenario.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_write, d_rsp_valid, d_rsp_err;
    logic [2:0]  d_req_funct3;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic        mem_write_mem;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address, mem_write_data, mem_read_address;
    logic [31:0] mem_read_data = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_req_valid     (if_req_valid),
        .if_req_ready     (if_req_ready),
        .if_req_addr      (if_req_addr),
        .if_rsp_valid     (if_rsp_valid),
        .if_rsp_data      (if_rsp_data),
        .d_req_valid      (d_req_valid),
        .d_req_ready      (d_req_ready),
        .d_req_write      (d_req_write),
        .d_req_funct3     (d_req_funct3),
        .d_req_addr       (d_req_addr),
        .d_req_wdata      (d_req_wdata),
        .d_rsp_valid      (d_rsp_valid),
        .d_rsp_data       (d_rsp_data),
        .d_rsp_err        (d_rsp_err),
        .mem_write_mem    (mem_write_mem),
        .mem_funct3       (mem_funct3),
        .mem_write_address(mem_write_address),
        .mem_write_data   (mem_write_data),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-lane store merge and load extraction of an RV32I memory.
    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [1:0] lo,
                                               input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        w = old;
        case (f3[1:0])
            2'b00:   w[8*lo +: 8]  = wd[7:0];
            2'b01:   w[8*lo +: 16] = wd[15:0];
            default: w = wd;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_view(input logic [31:0] w, input logic [1:0] lo,
                                              input logic [2:0] f3);
        logic [31:0] s;
        s = w >> (8*lo);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    bit [31:0] mem_env [bit [29:0]];
    bit [31:0] mem_mdl [bit [29:0]];

    function automatic logic [31:0] rd_env(input logic [31:0] a);
        return mem_env.exists(a[31:2]) ? mem_env[a[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_mdl(input logic [31:0] a);
        return mem_mdl.exists(a[31:2]) ? mem_mdl[a[31:2]] : 32'h0;
    endfunction

    // The memory the arbiter drives: write then registered read.
    always @(posedge clk) begin
        if (mem_write_mem)
            mem_env[mem_write_address[31:2]] = lane_merge(rd_env(mem_write_address),
                mem_write_address[1:0], mem_funct3, mem_write_data);
        mem_read_data <= load_view(rd_env(mem_read_address), mem_read_address[1:0], mem_funct3);
    end

    function automatic bit legal(input logic w, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (w) begin
            if (!(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
        end else if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            return 1'b0;
        end
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    // Reference model: m_wait = consecutive cycles a valid fetch lost;
    // m_pend = response owed next cycle (0 none, 1 fetch, 2 load, 3 store, 4 error).
    int          m_wait = 0;
    int          m_pend = 0;
    logic [31:0] m_pend_data = 32'h0;

    always @(negedge clk) begin : model
        bit          gd, gf, chk_r, chk_w, e_ifv, e_dv, e_err, e_we;
        logic [2:0]  e_f3;
        logic [31:0] e_raddr, e_waddr, e_wdata, nxt_data;
        int          nxt;
        gd = 1'b0;
        gf = 1'b0;
        if (!reset) begin
            gd = d_req_valid && !(if_req_valid && m_wait >= LIMIT);
            gf = if_req_valid && !gd;
        end
        e_ifv = !reset && m_pend == 1;
        e_dv  = !reset && m_pend >= 2;
        e_err = !reset && m_pend == 4;
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(e_ifv));
        chk("d_rsp_valid", 32'(d_rsp_valid), 32'(e_dv));
        chk("d_rsp_err", 32'(d_rsp_err), 32'(e_err));
        if (reset || e_ifv) chk("if_rsp_data", if_rsp_data, e_ifv ? m_pend_data : 32'h0);
        if (reset || e_dv) chk("d_rsp_data", d_rsp_data, e_dv ? m_pend_data : 32'h0);

        e_we = 1'b0; e_f3 = 3'b010; e_raddr = '0; e_waddr = '0; e_wdata = '0;
        chk_r = 1'b1; chk_w = 1'b1; nxt = 0; nxt_data = '0;
        if (gf) begin
            e_raddr  = if_req_addr;
            chk_w    = 1'b0;
            nxt      = 1;
            nxt_data = rd_mdl(if_req_addr);
        end else if (gd) begin
            if (!legal(d_req_write, d_req_funct3, d_req_addr)) begin
                nxt = 4;
            end else if (d_req_write) begin
                e_we = 1'b1; e_f3 = d_req_funct3; e_waddr = d_req_addr; e_wdata = d_req_wdata;
                chk_r = 1'b0;
                nxt = 3;
                mem_mdl[d_req_addr[31:2]] = lane_merge(rd_mdl(d_req_addr), d_req_addr[1:0],
                                                       d_req_funct3, d_req_wdata);
            end else begin
                e_f3 = d_req_funct3; e_raddr = d_req_addr;
                chk_w = 1'b0;
                nxt = 2;
                nxt_data = load_view(rd_mdl(d_req_addr), d_req_addr[1:0], d_req_funct3);
            end
        end
        chk("if_req_ready", 32'(if_req_ready), 32'(gf));
        chk("d_req_ready", 32'(d_req_ready), 32'(gd));
        chk("mem_write_mem", 32'(mem_write_mem), 32'(e_we));
        chk("mem_funct3", 32'(mem_funct3), 32'(e_f3));
        if (chk_r) chk("mem_read_address", mem_read_address, e_raddr);
        if (chk_w) begin
            chk("mem_write_address", mem_write_address, e_waddr);
            chk("mem_write_data", mem_write_data, e_wdata);
        end

        m_pend      = reset ? 0 : nxt;
        m_pend_data = nxt_data;
        if (reset || !if_req_valid || gf) m_wait = 0;
        else if (gd) m_wait = m_wait + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req_valid = 1'b0; if_req_addr = '0;
        d_req_valid = 1'b0; d_req_write = 1'b0; d_req_funct3 = 3'b010;
        d_req_addr = '0; d_req_wdata = '0;
    endtask

    // One data-only cycle, checking this cycle's acceptance and the previous response.
    task automatic dcyc(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_we, input bit chk_prev,
                        input logic [31:0] prev_data, input logic prev_err, input string tag);
        if_req_valid = 1'b0;
        d_req_valid = 1'b1; d_req_write = w; d_req_funct3 = f3;
        d_req_addr = a; d_req_wdata = wd;
        @(negedge clk);
        chk({tag, " ready"}, 32'(d_req_ready), 32'h1);
        chk({tag, " write_mem"}, 32'(mem_write_mem), 32'(exp_we));
        if (chk_prev) begin
            chk({tag, " prev rsp_valid"}, 32'(d_rsp_valid), 32'h1);
            chk({tag, " prev rsp_data"}, d_rsp_data, prev_data);
            chk({tag, " prev rsp_err"}, 32'(d_rsp_err), 32'(prev_err));
        end
        step();
    endtask

    task automatic dend(input logic [31:0] prev_data, input logic prev_err, input string tag);
        drive_idle();
        @(negedge clk);
        chk({tag, " last rsp_valid"}, 32'(d_rsp_valid), 32'h1);
        chk({tag, " last rsp_data"}, d_rsp_data, prev_data);
        chk({tag, " last rsp_err"}, 32'(d_rsp_err), 32'(prev_err));
        step();
    endtask

    logic [31:0] fw [3];
    logic [11:0] exp_f;
    int          run, longest;

    initial begin
        fw[0] = 32'h11111111; fw[1] = 32'h22222222; fw[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            mem_env[30'(i)] = fw[i];
            mem_mdl[30'(i)] = fw[i];
        end
        drive_idle();
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset if_req_ready", 32'(if_req_ready), 32'h0);
        chk("reset d_req_ready", 32'(d_req_ready), 32'h0);
        chk("reset mem_funct3", 32'(mem_funct3), 32'h2);
        step(); step();
        reset = 1'b0;

        // fetch only
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            if_req_valid = (i < 3);
            if_req_addr  = 32'(i * 4);
            @(negedge clk);
            if (i < 3) chk("fetch ready", 32'(if_req_ready), 32'h1);
            if (i > 0) begin
                chk("fetch rsp_valid", 32'(if_rsp_valid), 32'h1);
                chk("fetch rsp_data", if_rsp_data, fw[i-1]);
            end
            step();
        end

        // store then loads, including read-after-write
        dcyc(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0, "SW 0x100");
        dcyc(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, "LW 0x100");
        dcyc(1'b0, 3'b100, 32'h101, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, "LBU 0x101");
        dcyc(1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 1'b1, 32'h000000BE, 1'b0, "LB 0x103");
        dend(32'hFFFFFFDE, 1'b0, "LB 0x103");

        // contention
        exp_f = 12'b0010_0001_0000;
        if_req_valid = 1'b1; if_req_addr = 32'h8;
        d_req_valid = 1'b1; d_req_write = 1'b0; d_req_funct3 = 3'b010; d_req_addr = 32'h100;
        run = 0; longest = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("contend fetch grant", 32'(if_req_ready), 32'(exp_f[i]));
            chk("contend data grant", 32'(d_req_ready), 32'(!exp_f[i]));
            if (if_req_ready) run = 0;
            else run++;
            if (run > longest) longest = run;
            step();
        end
        chk("longest fetch wait", 32'(longest), 32'(LIMIT));
        drive_idle();
        step();

        // misaligned and illegal accesses
        dcyc(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "LW 0x102");
        dcyc(1'b1, 3'b001, 32'h101, 32'h1234, 1'b0, 1'b1, 32'h0, 1'b1, "SH 0x101");
        dcyc(1'b1, 3'b000, 32'h103, 32'hAB, 1'b1, 1'b1, 32'h0, 1'b1, "SB 0x103");
        dcyc(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, "LW 0x100 after SB");
        dend(32'hABADBEEF, 1'b0, "LW 0x100 after SB");

        // MMIO
        dcyc(1'b1, 3'b010, 32'hFFFFFFFC, 32'h80402010, 1'b1, 1'b0, 32'h0, 1'b0, "SW mmio");
        dcyc(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, "LW mmio");
        dend(32'h80402010, 1'b0, "LW mmio");

        // reset mid-operation with a partly charged starvation counter
        if_req_valid = 1'b1; if_req_addr = 32'h4;
        d_req_valid = 1'b1; d_req_write = 1'b0; d_req_funct3 = 3'b010; d_req_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pre-reset data grant", 32'(d_req_ready), 32'h1);
            step();
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("in-reset d_rsp_valid", 32'(d_rsp_valid), 32'h0);
            chk("in-reset if_req_ready", 32'(if_req_ready), 32'h0);
            chk("in-reset d_req_ready", 32'(d_req_ready), 32'h0);
            step();
        end
        reset = 1'b0;
        exp_f = 12'b0000_0001_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post-reset fetch grant", 32'(if_req_ready), 32'(exp_f[i]));
            step();
        end
        drive_idle();
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
